// File: rtl/uart_sender_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sender_if
//  Purpose  : Byte handshake between the word-to-byte sender buffer and the
//             serial transmitter. The buffer is the master and offers bytes;
//             the transmitter is the slave and accepts them with ready.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_sender_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    // Upstream buffer side: offers a byte, observes ready
    modport master (
        output data,
        output valid,
        input  ready
    );

    // Transmitter side: consumes a byte, reports ready
    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_sender.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sender
//  Purpose  : Asynchronous serial transmitter. Accepts one byte per
//             valid/ready handshake and sends start bit, 8 data bits LSB
//             first, optional parity and 1 or 2 stop bits on txd.
//  Revision : 1.0  initial release
// ============================================================================
module uart_sender #(
    parameter int CLKS_PER_BIT = 100,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  wire logic     CLK,
    input  wire logic     reset_n,
    uart_sender_if.slave  up,
    output logic          txd,
    output logic          busy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    // Baud counter width; guarded so a degenerate setting still elaborates.
    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

    // Unsupported parity / stop settings fall back to no parity, 1 stop bit.
    localparam int   c_PAR       = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
    localparam int   c_STOPS     = (STOP_BITS == 2) ? 2 : 1;
    localparam logic c_PAR_ODD   = (c_PAR == 2);
    localparam logic c_STOP_LAST = (c_STOPS == 2);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [2:0]      state_q, state_d;
    logic [c_CW-1:0] cnt_q,   cnt_d;     // cycles elapsed within current bit
    logic [2:0]      bit_q,   bit_d;     // index of data bit on the line
    logic            stop_q,  stop_d;    // index of stop bit on the line
    logic [7:0]      shift_q, shift_d;   // remaining data bits, LSB next
    logic            par_q,   par_d;     // XOR of data bits sent so far
    logic            txd_q,   txd_d;
    logic            ready_q, ready_d;
    logic            busy_q,  busy_d;

    logic w_hs;
    logic w_tick;

    assign w_hs   = up.valid && ready_q;
    assign w_tick = (cnt_q == c_CNT_MAX);

    // Next-state logic: one bit period per state visit, boundaries on w_tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        ready_d = ready_q;
        busy_d  = busy_q;

        // Baud counter runs in every frame state and restarts on each
        // bit boundary, so bit lengths never accumulate error.
        if (state_q != c_IDLE) begin
            cnt_d = w_tick ? '0 : (cnt_q + c_CNT_ONE);
        end

        case (state_q)
            c_IDLE: begin
                txd_d = 1'b1;
                if (w_hs) begin
                    // Start bit goes out from the accepting edge itself.
                    state_d = c_START;
                    shift_d = up.data;
                    par_d   = 1'b0;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    stop_d  = 1'b0;
                    txd_d   = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            c_START: begin
                if (w_tick) begin
                    state_d = c_DATA;
                    txd_d   = shift_q[0];
                    par_d   = par_q ^ shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end

            c_DATA: begin
                if (w_tick) begin
                    if (bit_q == 3'd7) begin
                        // par_q already folds in all eight data bits here.
                        if (c_PAR != 0) begin
                            state_d = c_PARITY;
                            txd_d   = par_q ^ c_PAR_ODD;
                        end else begin
                            state_d = c_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        par_d   = par_q ^ shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end

            c_PARITY: begin
                if (w_tick) begin
                    state_d = c_STOP;
                    txd_d   = 1'b1;
                end
            end

            c_STOP: begin
                if (w_tick) begin
                    if (stop_q == c_STOP_LAST) begin
                        // Frame complete: line idles and a new byte may be
                        // accepted from the very next edge.
                        state_d = c_IDLE;
                        txd_d   = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_d  = 1'b1;
                    end
                end
            end

            default: begin
                // Unreachable encodings recover to a clean idle line.
                state_d = c_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State update; reset abandons any frame and forces an idle line at once
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign up.ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_sender
//  Purpose  : Self-checking bench for uart_sender. Four instances cover no
//             parity, even parity with 2 stop bits, odd parity, and illegal
//             settings. A frame-level model predicts txd/ready/busy per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_sender;
    localparam int CPB = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       reset_n;
    logic [3:0] tv;
    logic [7:0] td [4];
    logic [3:0] dtxd, dbusy, drdy;

    uart_sender_if if0 ();
    uart_sender_if if1 ();
    uart_sender_if if2 ();
    uart_sender_if if3 ();

    assign if0.valid = tv[0]; assign if0.data = td[0]; assign drdy[0] = if0.ready;
    assign if1.valid = tv[1]; assign if1.data = td[1]; assign drdy[1] = if1.ready;
    assign if2.valid = tv[2]; assign if2.data = td[2]; assign drdy[2] = if2.ready;
    assign if3.valid = tv[3]; assign if3.data = td[3]; assign drdy[3] = if3.ready;

    uart_sender #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
        .CLK(CLK), .reset_n(reset_n), .up(if0), .txd(dtxd[0]), .busy(dbusy[0]));
    uart_sender #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u1 (
        .CLK(CLK), .reset_n(reset_n), .up(if1), .txd(dtxd[1]), .busy(dbusy[1]));
    uart_sender #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u2 (
        .CLK(CLK), .reset_n(reset_n), .up(if2), .txd(dtxd[2]), .busy(dbusy[2]));
    uart_sender #(.CLKS_PER_BIT(CPB), .PARITY(3), .STOP_BITS(5)) u3 (
        .CLK(CLK), .reset_n(reset_n), .up(if3), .txd(dtxd[3]), .busy(dbusy[3]));

    // Raw configuration of each instance, as instantiated above
    function automatic int cfg_par(input int i);
        case (i)
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_stop(input int i);
        case (i)
            1: return 2;
            3: return 5;
            default: return 1;
        endcase
    endfunction

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Frame model: on acceptance the whole frame is laid out as a bit list;
    // during the frame, cycle k after acceptance carries bit k/CPB.
    // ------------------------------------------------------------------
    int         cyc = 0;
    bit         m_act [4];
    int         m_k   [4];
    int         m_F   [4];
    logic [11:0] m_fr [4];
    int         acc_n [4];
    int         pe, se, nb;

    always @(posedge CLK) begin
        cyc = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
                m_act[i] = 1'b0;
            end else if (!m_act[i]) begin
                if (tv[i]) begin
                    pe = (cfg_par(i) == 1 || cfg_par(i) == 2) ? cfg_par(i) : 0;
                    se = (cfg_stop(i) == 2) ? 2 : 1;
                    m_fr[i] = '1;
                    m_fr[i][0] = 1'b0;
                    for (int b = 0; b < 8; b++) m_fr[i][1+b] = td[i][b];
                    nb = 9;
                    if (pe != 0) begin
                        m_fr[i][9] = (^td[i]) ^ (pe == 2);
                        nb = 10;
                    end
                    m_F[i]   = (nb + se) * CPB;
                    m_k[i]   = 0;
                    m_act[i] = 1'b1;
                    acc_n[i] = acc_n[i] + 1;
                end
            end else begin
                m_k[i] = m_k[i] + 1;
                if (m_k[i] == m_F[i]) m_act[i] = 1'b0;
            end
        end
    end

    // Line history per instance, indexed by the edge that started the cycle
    logic hist  [4][4096];
    logic rhist [4][4096];
    logic et, eb;

    // Per-cycle comparison of every instance against the model
    always @(negedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            eb = reset_n && m_act[i];
            et = eb ? m_fr[i][m_k[i] / CPB] : 1'b1;
            if (cmp_en) begin
                chk($sformatf("txd%0d", i),   {31'd0, dtxd[i]},  {31'd0, et});
                chk($sformatf("busy%0d", i),  {31'd0, dbusy[i]}, {31'd0, eb});
                chk($sformatf("ready%0d", i), {31'd0, drdy[i]},  {31'd0, !eb});
            end
            if (cyc < 4096) begin
                hist[i][cyc]  = dtxd[i];
                rhist[i][cyc] = drdy[i];
            end
        end
    end

    // Line decoder over recorded history: finds start bits, reads 8 data bits
    logic [7:0] dq[$];
    int         ds[$];
    task automatic scan(input int i, input int from, input int to, output int n);
        logic [7:0] b;
        n = 0;
        dq.delete();
        ds.delete();
        for (int c = from + 1; c <= to; c++) begin
            if (hist[i][c-1] == 1'b1 && hist[i][c] == 1'b0) begin
                for (int bb = 0; bb < 8; bb++) b[bb] = hist[i][c + CPB*(bb+1) + 2];
                dq.push_back(b);
                ds.push_back(c);
                n++;
                c = c + CPB*9;
            end
        end
    endtask

    // Offer one byte on an idle instance for exactly one cycle
    task automatic send(input int i, input logic [7:0] b, output int t);
        @(posedge CLK); #1;
        td[i] = b;
        tv[i] = 1'b1;
        @(posedge CLK); #1;
        t     = cyc;
        tv[i] = 1'b0;
    endtask

    int         t, n, j, w0, cnt;
    logic [9:0] seq;
    logic [31:0] word;

    initial begin
        reset_n = 1'b1;
        tv      = 4'b0;
        for (int i = 0; i < 4; i++) td[i] = 8'h00;
        #2 reset_n = 1'b0;
        #1 cmp_en  = 1'b1;

        // Reset then idle
        repeat (3) @(posedge CLK);
        #1 reset_n = 1'b1;
        w0 = cyc;
        repeat (50) @(posedge CLK);
        #1;
        cnt = 0;
        for (int c = w0; c < w0 + 50; c++) cnt += (hist[0][c] == 1'b0 || rhist[0][c] == 1'b0) ? 1 : 0;
        chk("idle_low_cycles", cnt, 0);

        // Single byte 0xA5
        send(0, 8'hA5, t);
        repeat (45) @(posedge CLK);
        seq = 10'b1101001010;
        for (int b = 0; b < 10; b++)
            chk($sformatf("a5_bit%0d", b), {31'd0, hist[0][t + CPB*b + 2]}, {31'd0, seq[b]});
        cnt = 0;
        for (int c = t - 2; c < t + 45; c++) cnt += (rhist[0][c] == 1'b0) ? 1 : 0;
        chk("a5_ready_low", cnt, 40);

        // Four-byte burst of 0xDEADBEEF, most significant byte first
        word = 32'hDEADBEEF;
        @(posedge CLK); #1;
        w0    = cyc;
        n     = acc_n[0];
        j     = 0;
        td[0] = word[31:24];
        tv[0] = 1'b1;
        for (int cy = 0; cy < 400 && j < 4; cy++) begin
            @(posedge CLK); #1;
            if (acc_n[0] != n + j) begin
                j++;
                if (j < 4) td[0] = word[31 - 8*j -: 8];
                else tv[0] = 1'b0;
            end
        end
        tv[0] = 1'b0;
        chk("burst_accepts", j, 4);
        repeat (45) @(posedge CLK); #1;
        scan(0, w0, cyc - 2, n);
        chk("burst_frames", n, 4);
        if (n == 4) begin
            chk("burst_b0", dq[0], 8'hDE);
            chk("burst_b1", dq[1], 8'hAD);
            chk("burst_b2", dq[2], 8'hBE);
            chk("burst_b3", dq[3], 8'hEF);
            for (int k = 0; k < 3; k++) chk("burst_period", ds[k+1] - ds[k], 41);
        end

        // Handshake stall: data changes while ready is low
        @(posedge CLK); #1;
        w0    = cyc;
        td[0] = 8'h11;
        tv[0] = 1'b1;
        repeat (20) begin
            @(posedge CLK); #1;
            td[0] = td[0] + 8'h11;
        end
        tv[0] = 1'b0;
        repeat (30) @(posedge CLK); #1;
        scan(0, w0, cyc - 2, n);
        chk("stall_frames", n, 1);
        if (n == 1) chk("stall_byte", dq[0], 8'h11);

        // Parity and stop-bit variants
        send(1, 8'h07, t);
        repeat (50) @(posedge CLK);
        chk("even_07_par", {31'd0, hist[1][t + 38]}, 1);
        cnt = 0;
        for (int c = t + 40; c < t + 48; c++) cnt += (hist[1][c] == 1'b1) ? 1 : 0;
        chk("two_stop_high", cnt, 8);
        chk("two_stop_rdy_lo", {31'd0, rhist[1][t + 47]}, 0);
        chk("two_stop_rdy_hi", {31'd0, rhist[1][t + 48]}, 1);

        send(1, 8'h00, t);
        repeat (50) @(posedge CLK);
        chk("even_00_par", {31'd0, hist[1][t + 38]}, 0);

        send(2, 8'h07, t);
        repeat (45) @(posedge CLK);
        chk("odd_07_par", {31'd0, hist[2][t + 38]}, 0);
        chk("odd_rdy_lo", {31'd0, rhist[2][t + 43]}, 0);
        chk("odd_rdy_hi", {31'd0, rhist[2][t + 44]}, 1);

        send(3, 8'h07, t);
        repeat (45) @(posedge CLK);
        chk("illegal_stop", {31'd0, hist[3][t + 38]}, 1);
        chk("illegal_rdy_lo", {31'd0, rhist[3][t + 39]}, 0);
        chk("illegal_rdy_hi", {31'd0, rhist[3][t + 40]}, 1);

        // Reset during data bit 3 of 0xA5 (a zero bit)
        send(0, 8'hA5, t);
        repeat (17) @(posedge CLK);
        #1;
        chk("pre_rst_txd", {31'd0, dtxd[0]}, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_txd",   {31'd0, dtxd[0]},  1);
        chk("rst_ready", {31'd0, drdy[0]},  1);
        chk("rst_busy",  {31'd0, dbusy[0]}, 0);
        repeat (3) @(posedge CLK);
        #1 reset_n = 1'b1;
        w0 = cyc;
        repeat (60) @(posedge CLK); #1;
        scan(0, w0, cyc - 2, n);
        chk("post_rst_frames", n, 0);

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
